// File: rtl/usb_fs_in_ep_packetizer.sv
`default_nettype none
// ============================================================================
// usb_fs_in_ep_packetizer - buffers a byte stream and cuts it into IN packets
// for one engine IN endpoint. Optional ZLP after full packet: USB_IN_EP_PACKETIZER_ZLP_EN
// Rev 1.0
// ============================================================================
module usb_fs_in_ep_packetizer #(
  parameter int MAX_PKT_SIZE  = 64,
  parameter int FIFO_DEPTH    = 128,
  parameter int FLUSH_TIMEOUT = 4800
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       ep_stall_req,
  output logic       in_ep_req,
  input  logic       in_ep_grant,
  input  logic       in_ep_data_free,
  output logic       in_ep_data_put,
  output logic [7:0] in_ep_data,
  output logic       in_ep_data_done,
  output logic       in_ep_stall,
  input  logic       in_ep_acked
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LEN_W = $clog2(MAX_PKT_SIZE + 1);
  localparam int TMO_W = $clog2(FLUSH_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] MAX_CNT   = CNT_W'(MAX_PKT_SIZE);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] LEN_MAX   = LEN_W'(MAX_PKT_SIZE);
  localparam logic [TMO_W-1:0] TMO_MAX   = TMO_W'(FLUSH_TIMEOUT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REQ      = 2'd1,
    FILL     = 2'd2,
    WAIT_ACK = 2'd3
  } state_t;

  state_t           state;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic [TMO_W-1:0] tmo;
  logic [LEN_W-1:0] pkt_len;
  logic [LEN_W-1:0] remaining;
  logic             zlp_pending;

  logic wr;
  logic rd;
  logic expired;
  logic data_go;
  logic zlp_go;
  logic last_put;

  assign wr       = s_valid && s_ready;
  assign rd       = in_ep_data_put;
  assign expired  = (tmo == TMO_MAX);
  assign data_go  = (count >= MAX_CNT) || ((count != '0) && expired);
  // A write in the same cycle ends the transfer with data instead of a ZLP.
  assign zlp_go   = zlp_pending && !wr;
  assign last_put = in_ep_data_put && (remaining == LEN_W'(1));

  assign in_ep_data_put = (state == FILL) && in_ep_grant && in_ep_data_free &&
                          (remaining != '0);
  assign in_ep_data     = (count != '0) ? mem[rd_ptr] : 8'h00;

  always_comb begin
    count_next = count;
    if (wr && !rd) begin
      count_next = count + CNT_W'(1);
    end else if (rd && !wr) begin
      count_next = count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      s_ready <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count   <= count_next;
      s_ready <= (count_next < DEPTH_CNT);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tmo <= '0;
    end else if (wr || (count == '0)) begin
      tmo <= '0;
    end else if ((state == IDLE) && !expired) begin
      tmo <= tmo + TMO_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      in_ep_stall <= 1'b0;
    end else begin
      in_ep_stall <= ep_stall_req;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state           <= IDLE;
      in_ep_req       <= 1'b0;
      in_ep_data_done <= 1'b0;
      pkt_len         <= '0;
      remaining       <= '0;
    end else begin
      in_ep_data_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!in_ep_stall && (data_go || zlp_go)) begin
            state     <= REQ;
            in_ep_req <= 1'b1;
            if (data_go) begin
              pkt_len <= (count >= MAX_CNT) ? LEN_MAX : LEN_W'(count);
            end else begin
              pkt_len <= '0;
            end
          end
        end
        REQ: begin
          // A grant already issued wins over a stall that arrives with it.
          if (in_ep_grant) begin
            state     <= FILL;
            remaining <= pkt_len;
          end else if (in_ep_stall) begin
            state     <= IDLE;
            in_ep_req <= 1'b0;
          end
        end
        FILL: begin
          if (in_ep_data_put) begin
            remaining <= remaining - LEN_W'(1);
          end
          if ((remaining == '0) || last_put) begin
            state           <= WAIT_ACK;
            in_ep_data_done <= 1'b1;
          end
        end
        WAIT_ACK: begin
          in_ep_req <= 1'b0;
          if (in_ep_acked) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ep_req <= 1'b0;
        end
      endcase
    end
  end

`ifdef USB_IN_EP_PACKETIZER_ZLP_EN
  // A full packet that drained the FIFO must be followed by a ZLP to end the transfer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      zlp_pending <= 1'b0;
    end else if ((state == WAIT_ACK) && in_ep_acked) begin
      zlp_pending <= (pkt_len == LEN_MAX) && (count == '0) && !wr;
    end else if ((state == IDLE) && wr) begin
      zlp_pending <= 1'b0;
    end
  end
`else
  assign zlp_pending = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_usb_fs_in_ep_packetizer.sv
`default_nettype none
// Testbench for usb_fs_in_ep_packetizer: queue-based stream model plus directed scenarios.
`timescale 1ns/1ps
module tb_usb_fs_in_ep_packetizer;

  localparam int MAX_PKT = 64;
  localparam int DEPTH   = 128;
  localparam int TO      = 4800;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_ready;
  logic       ep_stall_req = 1'b0;
  logic       in_ep_req;
  logic       in_ep_grant = 1'b0;
  logic       in_ep_data_free = 1'b1;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked = 1'b0;

  usb_fs_in_ep_packetizer #(
    .MAX_PKT_SIZE (MAX_PKT),
    .FIFO_DEPTH   (DEPTH),
    .FLUSH_TIMEOUT(TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .ep_stall_req   (ep_stall_req),
    .in_ep_req      (in_ep_req),
    .in_ep_grant    (in_ep_grant),
    .in_ep_data_free(in_ep_data_free),
    .in_ep_data_put (in_ep_data_put),
    .in_ep_data     (in_ep_data),
    .in_ep_data_done(in_ep_data_done),
    .in_ep_stall    (in_ep_stall),
    .in_ep_acked    (in_ep_acked)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Stream model: bytes accepted but not yet handed to the engine.
  logic [7:0] q[$];
  int         pkt_q[$];
  bit         mdl_rst = 1'b1;
  bit         prev_stall = 1'b0;
  bit         prev_done = 1'b0;
  bit         waiting = 1'b0;
  int         pkt_puts = 0;
  int         done_cnt = 0;

  always @(negedge clk) begin
    if (mdl_rst) begin
      chk("rst_outs", int'({s_ready, in_ep_req, in_ep_data_put, in_ep_data_done,
                            in_ep_stall, in_ep_data}), 0);
    end else begin
      chk("s_ready", int'(s_ready), int'(q.size() < DEPTH));
      chk("stall", int'(in_ep_stall), int'(prev_stall));
      if (in_ep_data_put) begin
        chk("put_cond", int'(in_ep_grant && in_ep_data_free && in_ep_req), 1);
        chk("put_nonempty", int'(q.size() != 0), 1);
        if (q.size() != 0) chk("put_data", int'(in_ep_data), int'(q[0]));
      end
      if (in_ep_data_done) begin
        chk("done_pulse", int'(prev_done), 0);
        chk("done_len_max", int'(pkt_puts <= MAX_PKT), 1);
        pkt_q.push_back(pkt_puts);
        done_cnt++;
      end
      if (waiting && !in_ep_data_done) chk("req_wait", int'(in_ep_req), 0);
    end
    if (!reset) begin
      q.delete();
      mdl_rst    = 1'b1;
      prev_stall = 1'b0;
      prev_done  = 1'b0;
      waiting    = 1'b0;
      pkt_puts   = 0;
    end else begin
      mdl_rst = 1'b0;
      if (in_ep_data_put) begin
        if (q.size() != 0) void'(q.pop_front());
        pkt_puts++;
      end
      if (s_valid && s_ready) q.push_back(s_data);
      prev_stall = ep_stall_req;
      prev_done  = in_ep_data_done;
      if (in_ep_data_done) begin
        waiting  = 1'b1;
        pkt_puts = 0;
      end
      if (in_ep_acked) waiting = 1'b0;
    end
  end

  // Engine emulation: grant while requested, optional grant drop, data_free toggle, auto ack.
  bit eng_en = 1'b0;
  bit free_toggle = 1'b0;
  bit auto_ack = 1'b0;
  bit dropped = 1'b0;
  int drop_at = 0;
  int drop_left = 0;
  int ack_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (drop_left > 0) drop_left--;
    if (drop_at != 0 && !dropped && pkt_puts >= drop_at) begin
      dropped   = 1'b1;
      drop_left = 5;
    end
    in_ep_grant     = eng_en && in_ep_req && (drop_left == 0);
    in_ep_data_free = free_toggle ? ~in_ep_data_free : 1'b1;
    if (auto_ack && waiting) begin
      ack_cnt++;
      in_ep_acked = (ack_cnt == 3);
    end else begin
      ack_cnt     = 0;
      in_ep_acked = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_burst(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      s_valid = 1'b1;
      s_data  = base + 8'(i);
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic send_byte(input string name, input logic [7:0] d, input int bound);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    while (!s_ready && n < bound) begin
      tick();
      n++;
    end
    chk(name, int'(s_ready), 1);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int target, input int bound);
    int n = 0;
    while (done_cnt < target && n < bound) begin
      tick();
      n++;
    end
    chk(name, int'(done_cnt >= target), 1);
  endtask

  task automatic wait_ack(input string name, input int bound);
    int n = 0;
    while (waiting && n < bound) begin
      tick();
      n++;
    end
    chk(name, int'(waiting), 0);
  endtask

  task automatic check_pkt(input string name, input int exp_len);
    chk({name, "_present"}, int'(pkt_q.size() != 0), 1);
    if (pkt_q.size() != 0) chk(name, pkt_q.pop_front(), exp_len);
  endtask

  task automatic zlp_phase(input string name);
`ifdef USB_IN_EP_PACKETIZER_ZLP_EN
    wait_done({name, "_zlp_done"}, done_cnt + 1, 60);
    check_pkt({name, "_zlp_len"}, 0);
    wait_ack({name, "_zlp_ack"}, 20);
`else
    bit seen = 1'b0;
    repeat (40) begin
      tick();
      seen |= in_ep_req;
    end
    chk({name, "_no_zlp"}, int'(seen), 0);
`endif
  endtask

  initial begin
    int n;
    bit seen;

    repeat (3) tick();
    chk("rst_ready", int'(s_ready), 0);
    chk("rst_req", int'(in_ep_req), 0);
    reset = 1'b1;
    tick();
    chk("post_rst_ready", int'(s_ready), 1);

    // Full packet: req one cycle after the 64th write, held off until ack.
    eng_en = 1'b1;
    write_burst(64, 8'h00);
    chk("t1_fifo", q.size(), 64);
    chk("t1_req_early", int'(in_ep_req), 0);
    tick();
    chk("t1_req_lat", int'(in_ep_req), 1);
    wait_done("t1_done", done_cnt + 1, 200);
    check_pkt("t1_len", 64);
    repeat (10) tick();
    chk("t1_req_hold", int'(in_ep_req), 0);
    auto_ack = 1'b1;
    wait_ack("t1_ack", 20);
    zlp_phase("t1");

    // Short packet: counter reaches TO cycles after the last write, req one cycle later.
    write_burst(10, 8'h40);
    n = 0;
    while (!in_ep_req && n < TO + 100) begin
      tick();
      n++;
    end
    chk("t2_timeout", n, TO + 1);
    wait_done("t2_done", done_cnt + 1, 100);
    check_pkt("t2_len", 10);
    wait_ack("t2_ack", 20);

    // Backpressure: FIFO fills at 128 with no grant, then drains as 64, 64, 2.
    eng_en = 1'b0;
    write_burst(128, 8'h80);
    chk("t3_full", int'(s_ready), 0);
    chk("t3_cnt", q.size(), 128);
    chk("t3_req", int'(in_ep_req), 1);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    repeat (5) tick();
    chk("t3_stuck", int'(s_ready), 0);
    n = done_cnt;
    eng_en = 1'b1;
    send_byte("t3_b128", 8'hEE, 300);
    send_byte("t3_b129", 8'hEF, 300);
    wait_done("t3_done", n + 3, TO + 1000);
    check_pkt("t3_len0", 64);
    check_pkt("t3_len1", 64);
    check_pkt("t3_len2", 2);
    wait_ack("t3_ack", 20);

    // Grant drop after put #20 with data_free toggling.
    free_toggle = 1'b1;
    dropped     = 1'b0;
    drop_at     = 20;
    write_burst(64, 8'h10);
    wait_done("t4_done", done_cnt + 1, 400);
    check_pkt("t4_len", 64);
    chk("t4_dropped", int'(dropped), 1);
    wait_ack("t4_ack", 20);
    free_toggle = 1'b0;
    drop_at     = 0;
    zlp_phase("t4");

    // Reset in the middle of a packet.
    write_burst(64, 8'hA0);
    n = 0;
    while (pkt_puts < 30 && n < 200) begin
      tick();
      n++;
    end
    chk("t5_puts30", int'(pkt_puts >= 30), 1);
    reset = 1'b0;
    tick();
    chk("t5_req", int'(in_ep_req), 0);
    chk("t5_put", int'(in_ep_data_put), 0);
    chk("t5_done", int'(in_ep_data_done), 0);
    chk("t5_ready", int'(s_ready), 0);
    chk("t5_data", int'(in_ep_data), 0);
    chk("t5_stall", int'(in_ep_stall), 0);
    tick();
    reset = 1'b1;
    tick();
    chk("t5_ready_back", int'(s_ready), 1);
    chk("t5_empty", int'(in_ep_data), 0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= in_ep_req;
    end
    chk("t5_noreq", int'(seen), 0);

    // Stall: registered one cycle, blocks requests until released.
    ep_stall_req = 1'b1;
    chk("t6_stall0", int'(in_ep_stall), 0);
    tick();
    chk("t6_stall1", int'(in_ep_stall), 1);
    write_burst(64, 8'h60);
    seen = 1'b0;
    repeat (20) begin
      tick();
      seen |= in_ep_req;
    end
    chk("t6_noreq", int'(seen), 0);
    ep_stall_req = 1'b0;
    tick();
    chk("t6_unstall", int'(in_ep_stall), 0);
    chk("t6_req_wait", int'(in_ep_req), 0);
    tick();
    chk("t6_req", int'(in_ep_req), 1);
    wait_done("t6_done", done_cnt + 1, 200);
    check_pkt("t6_len", 64);
    wait_ack("t6_ack", 20);
    zlp_phase("t6");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/usb_fs_in_ep_packetizer.md
Name: usb_fs_in_ep_packetizer

Overview:
- Endpoint-side client of the protocol engine's IN endpoint interface (req/grant/data_free/data_put/data/data_done/stall/acked).
- Accepts a byte stream, buffers it in an internal FIFO and cuts it into USB IN packets of at most MAX_PKT_SIZE bytes.
- Hands each packet to the engine and holds off the next packet until the engine reports the host ACK.
- Sits between an application byte source (e.g. bootloader reply path) and one IN endpoint slot of the engine.

Parameters:
- MAX_PKT_SIZE, 64, maximum bytes per IN packet (1..64).
- FIFO_DEPTH, 128, stream FIFO depth in bytes; power of two, >= MAX_PKT_SIZE.
- FLUSH_TIMEOUT, 4800, idle clk cycles after the last stream write before a short packet is sent (>= 1).

Ports:
- clk  in  1  block clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- s_valid  in  1  stream byte valid.
- s_data  in  8  stream byte.
- s_ready  out  1  FIFO can accept a byte.
- ep_stall_req  in  1  application request to stall the endpoint.
- in_ep_req  out  1  request for the engine's IN buffer.
- in_ep_grant  in  1  buffer granted.
- in_ep_data_free  in  1  engine buffer has room.
- in_ep_data_put  out  1  write in_ep_data this cycle.
- in_ep_data  out  8  byte to engine.
- in_ep_data_done  out  1  one-cycle pulse: packet complete, ready to send.
- in_ep_stall  out  1  endpoint stalled.
- in_ep_acked  in  1  one-cycle pulse: host ACKed the packet.

Behaviour:
- Reset (reset=0 at a clk edge): FIFO empty, state IDLE, timeout counter 0, zlp_pending 0. All outputs 0, including s_ready.
- FIFO:
  - s_ready = count < FIFO_DEPTH.
  - A byte is written when s_valid && s_ready.
  - A byte is read on every in_ep_data_put.
  - Simultaneous write and read leave count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
- in_ep_data is the FIFO head, combinational from the read pointer. It is valid whenever the FIFO is non-empty.
- Timeout counter:
  - Cleared on any stream write, and whenever the FIFO is empty.
  - Otherwise increments in IDLE, saturating at FLUSH_TIMEOUT.
  - expired = (counter == FLUSH_TIMEOUT).
- State IDLE:
  - Go to REQ if count >= MAX_PKT_SIZE, or (count > 0 && expired), or zlp_pending.
  - On entry to REQ, latch pkt_len = min(count, MAX_PKT_SIZE), or 0 if the trigger is zlp_pending alone.
- State REQ: in_ep_req=1. On in_ep_grant go to FILL with remaining = pkt_len.
- State FILL:
  - in_ep_req=1.
  - in_ep_data_put = in_ep_grant && in_ep_data_free && remaining != 0; each put decrements remaining.
  - If grant drops mid-packet, puts pause and resume when grant returns; no byte is lost or duplicated.
  - When remaining == 0 (immediately if pkt_len == 0): pulse in_ep_data_done for one cycle, drop in_ep_req next cycle, go to WAIT_ACK.
- State WAIT_ACK:
  - in_ep_req=0.
  - On in_ep_acked go to IDLE; stream writes continue meanwhile.
  - NAK/retry is handled by the engine; the block takes no action.
  - ZLP bookkeeping on ack is described under Optional Feature.
- in_ep_acked outside WAIT_ACK is ignored.
- Stall:
  - in_ep_stall is registered from ep_stall_req (1-cycle latency).
  - While stalled the block stays in or returns to IDLE only after the current WAIT_ACK completes, and issues no new requests.
  - FIFO contents are kept.
- Latency: a full packet's worth of bytes reaches REQ 1 cycle after the write that made count >= MAX_PKT_SIZE.

Optional Feature:
- Macro: USB_IN_EP_PACKETIZER_ZLP_EN.
- Defined:
  - On in_ep_acked, set zlp_pending if the acked packet had pkt_len == MAX_PKT_SIZE and the FIFO is empty.
  - zlp_pending is cleared when its ZLP is acked, or on any stream write before entering REQ (data will end the transfer instead).
- Undefined: zlp_pending is held at 0; no zero-length packets are ever sent.

Test Plan:
- Write 64 bytes 0x00..0x3F back-to-back, engine grants with data_free=1 -> REQ 1 cycle after byte 64; 64 puts in order 0x00..0x3F; one data_done pulse; req low until acked.
- Write 10 bytes, then idle -> no req until FLUSH_TIMEOUT cycles after the 10th write; then a 10-byte packet, data_done, awaits ack.
- Write 130 bytes with FIFO_DEPTH=128 and the engine never granting -> s_ready=0 after 128 writes; after grant and ack, s_ready returns and packets of 64, 64, 2 are sent.
- Drop grant for 5 cycles after put #20, and toggle data_free -> exactly 64 puts total with no gaps in the byte sequence.
- With ZLP_EN, write exactly 64 bytes and ack -> second packet with pkt_len 0: data_done pulse with zero puts. Without ZLP_EN -> no second request.
- Assert reset=0 mid-FILL (after 30 puts) -> next cycle all outputs 0, FIFO empty; ep_stall_req=1 -> in_ep_stall=1 one cycle later, no req issued.
